// File: rtl/pipeline_wb.sv
// ============================================================================
// Module      : pipeline_wb
// Description : Write-back stage merging MEM loads and ALU results onto the
//               single register-file write port, with an in-order ALU FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_wb #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic [4:0]                 reg_write,
    output logic [31:0]                data_write,
    output logic [$clog2(DEPTH+1)-1:0] pending_count,
    output logic                       wb_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_reg_write;
    logic [31:0]   r_data_write;

    logic w_empty;
    logic w_alu_acc;
    logic w_alu_live;
    logic w_mem_take;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic [4:0] w_push_rd;

    assign w_empty    = (r_count == '0);
    assign alu_ready  = rst & (r_count != c_full_count);
    assign w_alu_acc  = alu_valid & alu_ready;
    assign w_alu_live = w_alu_acc & (alu_rd != 5'd0);
    assign w_mem_take = rst & mem_valid & (mem_rd != 5'd0);

    // Priority: MEM, then FIFO head, then ALU bypass (only with FIFO empty).
    assign w_pop      = rst & ~w_mem_take & ~w_empty;
    assign w_bypass   = ~w_mem_take & w_empty & w_alu_live;
    assign w_push     = w_alu_live & ~w_bypass;

    // A load to the same rd is younger, so the queued ALU write must not land.
    assign w_push_rd  = (w_mem_take && (alu_rd == mem_rd)) ? 5'd0 : alu_rd;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mem_take && (r_rd[i] == mem_rd)) begin
                r_rd[i] <= 5'd0;
            end
        end
        if (w_push) begin
            r_rd[r_tail]   <= w_push_rd;
            r_data[r_tail] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reg_write  <= 5'd0;
            r_data_write <= 32'd0;
        end else if (w_mem_take) begin
            r_reg_write  <= mem_rd;
            r_data_write <= mem_data;
        end else if (w_pop) begin
            r_reg_write  <= r_rd[r_head];
            r_data_write <= r_data[r_head];
        end else if (w_bypass) begin
            r_reg_write  <= alu_rd;
            r_data_write <= alu_data;
        end else begin
            r_reg_write  <= 5'd0;
        end
    end

    assign reg_write     = r_reg_write;
    assign data_write    = r_data_write;
    assign pending_count = r_count;
    assign wb_idle       = w_empty & (r_reg_write == 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_pipeline_wb.sv
// ============================================================================
// Module      : tb_pipeline_wb
// Description : Directed self-checking bench for pipeline_wb (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_wb;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  reg_write;
    logic [31:0] data_write;
    logic [2:0]  pending_count;
    logic        wb_idle;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_wb #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .reg_write     (reg_write),
        .data_write    (data_write),
        .pending_count (pending_count),
        .wb_idle       (wb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
    endtask

    initial begin
        logic [4:0] exp_seq [7];
        int         k;
        logic       acc;

        rst = 1'b0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_data_write", data_write, 32'd0);
        chk("rst_pending", 32'(pending_count), 32'd0);
        chk("rst_idle", 32'(wb_idle), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(alu_ready), 32'd1);

        // Bypass
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        idle_inputs();
        chk("byp_rd", 32'(reg_write), 32'd5);
        chk("byp_data", data_write, 32'h1234);
        chk("byp_pending", 32'(pending_count), 32'd0);
        tick();
        chk("byp_after_rd", 32'(reg_write), 32'd0);
        chk("byp_after_idle", 32'(wb_idle), 32'd1);

        // MEM priority and queueing
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB;
        tick();
        idle_inputs();
        chk("prio_mem_rd", 32'(reg_write), 32'd3);
        chk("prio_mem_data", data_write, 32'hAAAA);
        chk("prio_pending1", 32'(pending_count), 32'd1);
        tick();
        chk("prio_alu_rd", 32'(reg_write), 32'd4);
        chk("prio_alu_data", data_write, 32'hBBBB);
        chk("prio_pending0", 32'(pending_count), 32'd0);
        tick();
        chk("prio_done", 32'(reg_write), 32'd0);

        // Full / backpressure: 6 MEM cycles, ALU offers 10..15
        k = 10;
        for (int i = 0; i < 6; i++) begin
            mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'(i + 100);
            alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'(k) << 8;
            #1;
            chk($sformatf("full_ready_%0d", i), 32'(alu_ready), (i < 4) ? 32'd1 : 32'd0);
            acc = alu_valid & alu_ready;
            tick();
            if (acc) k++;
            chk($sformatf("full_mem_rd_%0d", i), 32'(reg_write), 32'd1);
            chk($sformatf("full_mem_data_%0d", i), data_write, 32'(i + 100));
        end
        chk("full_pending", 32'(pending_count), 32'd4);
        chk("full_accepted", 32'(k), 32'd14);
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
        for (int j = 0; j < 7; j++) begin
            alu_valid = (k <= 15);
            alu_rd    = (k <= 15) ? 5'(k) : 5'd0;
            alu_data  = 32'(k) << 8;
            #1;
            acc = alu_valid & alu_ready;
            tick();
            if (acc) k++;
            chk($sformatf("drain_rd_%0d", j), 32'(reg_write), 32'(exp_seq[j]));
            if (exp_seq[j] != 5'd0)
                chk($sformatf("drain_data_%0d", j), data_write, 32'(exp_seq[j]) << 8);
        end
        idle_inputs();
        chk("drain_pending", 32'(pending_count), 32'd0);
        chk("drain_idle", 32'(wb_idle), 32'd1);

        // Collision kill
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick();
        idle_inputs();
        chk("kill_rd2", 32'(reg_write), 32'd2);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h2;
        tick();
        idle_inputs();
        chk("kill_rd7", 32'(reg_write), 32'd7);
        chk("kill_data7", data_write, 32'h2);
        chk("kill_pending1", 32'(pending_count), 32'd1);
        tick();
        chk("kill_bubble", 32'(reg_write), 32'd0);
        chk("kill_pending0", 32'(pending_count), 32'd0);
        tick();
        chk("kill_after", 32'(reg_write), 32'd0);
        chk("kill_idle", 32'(wb_idle), 32'd1);

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        tick();
        idle_inputs();
        chk("x0_alu_rd", 32'(reg_write), 32'd0);
        chk("x0_alu_pending", 32'(pending_count), 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        tick();
        idle_inputs();
        chk("x0_mem_byp_rd", 32'(reg_write), 32'd6);
        chk("x0_mem_byp_data", data_write, 32'h66);
        chk("x0_mem_pending", 32'(pending_count), 32'd0);

        // Reset mid-operation with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h900;
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(20 + i);
            tick();
        end
        idle_inputs();
        chk("mid_pending3", 32'(pending_count), 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_ready_low", 32'(alu_ready), 32'd0);
        tick();
        chk("mid_rd", 32'(reg_write), 32'd0);
        chk("mid_pending0", 32'(pending_count), 32'd0);
        chk("mid_idle", 32'(wb_idle), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mid_quiet_%0d", i), 32'(reg_write), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_wb.md
# pipeline_wb

Write-back stage feeding the single register-file write port (`reg_write` / `data_write`) consumed by the ID stage's register file. It merges two producers onto one port:

- ALU results from EX, with a valid/ready handshake.
- Load results from MEM, which have no backpressure and always win.

ALU results that lose arbitration are held in a small in-order FIFO. A register index of 0 on the output means "no write this cycle".

## Interface

Parameters:
- `DEPTH`, default 4: ALU holding-FIFO entries (power of two, ≥2).

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset; synchronous, active-low.
- `alu_valid`  input  1  ALU result offered.
- `alu_ready`  output  1  stage accepts ALU result this cycle.
- `alu_rd`  input  5  ALU destination register.
- `alu_data`  input  32  ALU result.
- `mem_valid`  input  1  load result present; must be taken this cycle.
- `mem_rd`  input  5  load destination register.
- `mem_data`  input  32  load data.
- `reg_write`  output  5  register-file write index, registered; 0 = idle.
- `data_write`  output  32  register-file write data, registered.
- `pending_count`  output  clog2(DEPTH+1)  current FIFO occupancy.
- `wb_idle`  output  1  FIFO empty and `reg_write == 0`.

## Operation

- **ALU accept:** an ALU result is accepted when `alu_valid & alu_ready`.
  - `alu_ready = rst & (pending_count != DEPTH)`.
  - No pop-through: when the FIFO is full, `alu_ready` is 0 even if a pop happens in the same cycle.
- **MEM take:** a MEM result is taken when `mem_valid & (mem_rd != 0)`. A MEM result with `mem_rd == 0` is ignored entirely and does not claim the port.
- **Port arbitration**, one write per cycle, strict priority:
  1. Taken MEM result.
  2. FIFO head (pop).
  3. Accepted ALU result, bypass; only when the FIFO is empty.
- **FIFO push:** an accepted ALU result with `alu_rd != 0` that does not win the port is pushed to the FIFO tail. An accepted ALU result with `alu_rd == 0` is consumed and discarded: no push, no port use.
- **Collision kill:** a taken MEM result is architecturally younger than every queued ALU entry. Every FIFO entry, including one being pushed this cycle, whose rd equals `mem_rd` has its rd forced to 0.
  - Killed entries still occupy a slot and are popped in order.
  - Popping a killed entry produces `reg_write = 0` for that cycle.
- **FIFO order:** strict FIFO order; entries never reorder.
- **Occupancy:** `pending_count` is +1 on push, −1 on pop, unchanged on simultaneous push and pop. It never exceeds `DEPTH` and never underflows.
- **Pointers:** head and tail are log2(DEPTH)-bit and wrap modulo `DEPTH`.

## Timing

- **Reset:** while `rst` is low at a rising edge:
  - `reg_write = 0`, `data_write = 0`.
  - FIFO emptied: pointers 0, `pending_count = 0`.
  - `wb_idle` = 1 from the cycle after that edge.
  - `alu_ready = 0` combinationally while `rst` is low.
- **Reset mid-operation:** all queued entries are dropped and no write is issued in the following cycle.
- **Latency:**
  - MEM or bypassed ALU: input sampled at edge N appears on `reg_write` / `data_write` after edge N, i.e. 1 cycle.
  - Queued ALU result: 1 cycle after the edge at which it is popped.
- **Write holding:** `reg_write` / `data_write` hold a write for exactly one cycle and then return to `reg_write = 0`, unless another write follows. `data_write` may keep its last value when idle.
- **Throughput:** sustained one write per cycle. With continuous MEM traffic, the FIFO fills in `DEPTH` cycles, then `alu_ready` drops.
- **Register file timing:** the register file samples the write on the next rising edge after it appears on the outputs, so the total result-to-architectural-state delay is 2 cycles.

## Test plan

- **Bypass:** after reset, `alu_valid=1`, `alu_rd=5`, `alu_data=0x1234`, no MEM.
  - Next cycle: `reg_write=5`, `data_write=0x1234`, `pending_count=0`.
  - Cycle after: `reg_write=0`, `wb_idle=1`.
- **MEM priority and queueing:** in the same cycle, MEM (rd=3, 0xAAAA) and ALU (rd=4, 0xBBBB).
  - Cycle+1: write rd3/0xAAAA, `pending_count=1`.
  - Cycle+2: write rd4/0xBBBB, `pending_count=0`.
- **Full/backpressure:** MEM writes rd=1 continuously for 6 cycles while ALU offers rd=10..15.
  - Entries 10..13 are accepted.
  - `alu_ready=0` once `pending_count=4`.
  - After MEM stops: writes 10, 11, 12, 13 appear in order, then 14, 15 after they are accepted.
  - Pointers wrap with no loss.
- **Collision kill:**
  - ALU rd=7 (0x1) is queued behind a MEM write to rd=2.
  - Next cycle: MEM rd=7 (0x2).
  - Outputs: rd2, then rd7/0x2, then a `reg_write=0` bubble for the killed entry; rd7 is never rewritten to 0x1.
- **x0 handling:**
  - ALU rd=0 accepted with FIFO empty: no write, `pending_count` stays 0.
  - MEM rd=0 alongside ALU rd=6: ALU bypasses, write rd6 next cycle.
- **Reset mid-operation:** with 3 entries queued, drive `rst=0` for one cycle.
  - Next cycle: `reg_write=0`, `pending_count=0`, `alu_ready=0` during reset.
  - No queued data ever appears afterwards.
